// File: rtl/sram_pixel_arbiter.sv
// sram_pixel_arbiter: shares one 16-bit asynchronous SRAM between the VGA
// display fetch path and the stroke renderer. Each 24-bit pixel occupies two
// consecutive words, so every access is a two-cycle burst (even word, then
// odd word). The display has priority. A starvation counter forces the
// painter through after STARVE_LIMIT display grants. Every output comes
// straight from a flop.
module sram_pixel_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = 19
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // display fetch port (read only)
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_ack,
  output logic              o_disp_valid,
  output logic [15:0]       o_disp_data_1,
  output logic [15:0]       o_disp_data_2,
  // painter port (read / write)
  input  logic              i_pnt_req,
  input  logic              i_pnt_we,
  input  logic [ADDR_W-1:0] i_pnt_addr,
  input  logic [15:0]       i_pnt_wdata_1,
  input  logic [15:0]       i_pnt_wdata_2,
  output logic              o_pnt_ack,
  output logic              o_pnt_valid,
  output logic [15:0]       o_pnt_rdata_1,
  output logic [15:0]       o_pnt_rdata_2,
  // external SRAM pins
  output logic [ADDR_W:0]   o_SRAM_ADDR,
  inout  wire  [15:0]       io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;
  typedef enum logic {OWN_DISP, OWN_PNT} owner_t;

  // Burst context
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_1_q, wdata_1_d;
  logic [15:0]       wdata_2_q, wdata_2_d;
  logic [15:0]       word_1_q, word_1_d;       // even word captured mid-burst
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  // Registered requester-side outputs
  logic        disp_ack_q, disp_ack_d;
  logic        disp_valid_q, disp_valid_d;
  logic [15:0] disp_data_1_q, disp_data_1_d;
  logic [15:0] disp_data_2_q, disp_data_2_d;
  logic        pnt_ack_q, pnt_ack_d;
  logic        pnt_valid_q, pnt_valid_d;
  logic [15:0] pnt_rdata_1_q, pnt_rdata_1_d;
  logic [15:0] pnt_rdata_2_q, pnt_rdata_2_d;

  // Registered SRAM pin drivers
  logic [ADDR_W:0] sram_addr_q, sram_addr_d;
  logic            sram_we_n_q, sram_we_n_d;
  logic            sram_oe_n_q, sram_oe_n_d;
  logic            sram_ce_n_q, sram_ce_n_d;
  logic            dq_oe_q, dq_oe_d;
  logic [15:0]     dq_out_q, dq_out_d;

  // Arbitration decision, only meaningful at IDLE and at the end of ACC1
  logic arb_point;
  logic pnt_win;
  logic disp_win;

  // Grant selection: painter if display is quiet or the painter is starved
  always_comb begin
    arb_point = (state_q == IDLE) || (state_q == ACC1);
    pnt_win   = arb_point && i_pnt_req && (!i_disp_req || starve_cnt_q == STARVE_MAX);
    disp_win  = arb_point && !pnt_win && i_disp_req;
  end

  // Next-state, burst sequencing, read completion and starvation tracking
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case
    // leaves one unassigned; a missing default here would infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_1_d     = wdata_1_q;
    wdata_2_d     = wdata_2_q;
    word_1_d      = word_1_q;
    starve_cnt_d  = starve_cnt_q;
    disp_ack_d    = 1'b0;
    disp_valid_d  = 1'b0;
    disp_data_1_d = disp_data_1_q;
    disp_data_2_d = disp_data_2_q;
    pnt_ack_d     = 1'b0;
    pnt_valid_d   = 1'b0;
    pnt_rdata_1_d = pnt_rdata_1_q;
    pnt_rdata_2_d = pnt_rdata_2_q;
    sram_addr_d   = sram_addr_q;
    sram_we_n_d   = sram_we_n_q;
    sram_oe_n_d   = sram_oe_n_q;
    sram_ce_n_d   = sram_ce_n_q;
    dq_oe_d       = dq_oe_q;
    dq_out_d      = dq_out_q;

    unique case (state_q)
      IDLE: begin
        // nothing to finish; a grant below launches the next burst
      end
      ACC0: begin
        if (!we_q) begin
          word_1_d = io_SRAM_DQ;
        end
        state_d     = ACC1;
        sram_addr_d = {addr_q, 1'b1};
        dq_out_d    = wdata_2_q;
      end
      ACC1: begin
        if (!we_q) begin
          if (owner_q == OWN_DISP) begin
            disp_valid_d  = 1'b1;
            disp_data_1_d = word_1_q;
            disp_data_2_d = io_SRAM_DQ;
          end else begin
            pnt_valid_d   = 1'b1;
            pnt_rdata_1_d = word_1_q;
            pnt_rdata_2_d = io_SRAM_DQ;
          end
        end
        // park the bus; overridden below on a back-to-back grant
        state_d     = IDLE;
        sram_we_n_d = 1'b1;
        sram_oe_n_d = 1'b1;
        sram_ce_n_d = 1'b1;
        dq_oe_d     = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pnt_win || disp_win) begin
      owner_d     = pnt_win ? OWN_PNT : OWN_DISP;
      we_d        = pnt_win && i_pnt_we;
      addr_d      = pnt_win ? i_pnt_addr : i_disp_addr;
      wdata_1_d   = i_pnt_wdata_1;
      wdata_2_d   = i_pnt_wdata_2;
      disp_ack_d  = disp_win;
      pnt_ack_d   = pnt_win;
      state_d     = ACC0;
      sram_addr_d = {addr_d, 1'b0};
      sram_we_n_d = !we_d;
      sram_oe_n_d = we_d;
      sram_ce_n_d = 1'b0;
      dq_oe_d     = we_d;
      dq_out_d    = i_pnt_wdata_1;
    end

    if (!i_pnt_req || pnt_win) begin
      starve_cnt_d = '0;
    end else if (disp_win && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // State and output registers; reset parks the SRAM and discards any burst
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignment only, so every
      // flop samples the pre-edge value of every other flop.
      state_q       <= IDLE;
      owner_q       <= OWN_DISP;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_1_q     <= '0;
      wdata_2_q     <= '0;
      word_1_q      <= '0;
      starve_cnt_q  <= '0;
      disp_ack_q    <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_data_1_q <= '0;
      disp_data_2_q <= '0;
      pnt_ack_q     <= 1'b0;
      pnt_valid_q   <= 1'b0;
      pnt_rdata_1_q <= '0;
      pnt_rdata_2_q <= '0;
      sram_addr_q   <= '0;
      sram_we_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      sram_ce_n_q   <= 1'b1;
      dq_oe_q       <= 1'b0;
      dq_out_q      <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_1_q     <= wdata_1_d;
      wdata_2_q     <= wdata_2_d;
      word_1_q      <= word_1_d;
      starve_cnt_q  <= starve_cnt_d;
      disp_ack_q    <= disp_ack_d;
      disp_valid_q  <= disp_valid_d;
      disp_data_1_q <= disp_data_1_d;
      disp_data_2_q <= disp_data_2_d;
      pnt_ack_q     <= pnt_ack_d;
      pnt_valid_q   <= pnt_valid_d;
      pnt_rdata_1_q <= pnt_rdata_1_d;
      pnt_rdata_2_q <= pnt_rdata_2_d;
      sram_addr_q   <= sram_addr_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_oe_n_q   <= sram_oe_n_d;
      sram_ce_n_q   <= sram_ce_n_d;
      dq_oe_q       <= dq_oe_d;
      dq_out_q      <= dq_out_d;
    end
  end

  assign io_SRAM_DQ    = dq_oe_q ? dq_out_q : 16'bz;
  assign o_SRAM_ADDR   = sram_addr_q;
  assign o_SRAM_WE_N   = sram_we_n_q;
  assign o_SRAM_OE_N   = sram_oe_n_q;
  assign o_SRAM_CE_N   = sram_ce_n_q;
  assign o_SRAM_LB_N   = sram_ce_n_q;
  assign o_SRAM_UB_N   = sram_ce_n_q;
  assign o_disp_ack    = disp_ack_q;
  assign o_disp_valid  = disp_valid_q;
  assign o_disp_data_1 = disp_data_1_q;
  assign o_disp_data_2 = disp_data_2_q;
  assign o_pnt_ack     = pnt_ack_q;
  assign o_pnt_valid   = pnt_valid_q;
  assign o_pnt_rdata_1 = pnt_rdata_1_q;
  assign o_pnt_rdata_2 = pnt_rdata_2_q;

endmodule

// File: doc/sram_pixel_arbiter.md
# sram_pixel_arbiter

Shares the single 16-bit SRAM port between the VGA display fetch path and the painterly stroke renderer. Each 24-bit pixel occupies two SRAM words, data_1 at even and data_2 at odd address, and is unpacked downstream into R/G/B. The block sequences every pixel access as a two-cycle SRAM burst. The display has priority, and a starvation guard ensures the painter still makes progress. It sits between the top-level datapath and the external SRAM pins.

## Interface
- STARVE_LIMIT, 8: consecutive display grants allowed while the painter waits before the painter is forced through.
- ADDR_W, 19: pixel address width; SRAM word address is ADDR_W+1 bits.

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_disp_req  in  1  display read request; held with stable address until ack.
- i_disp_addr  in  ADDR_W  display pixel address.
- o_disp_ack  out  1  one-cycle pulse: request accepted.
- o_disp_valid  out  1  one-cycle pulse: read data valid.
- o_disp_data_1, o_disp_data_2  out  16 each  words read from even/odd address.
- i_pnt_req  in  1  painter request; held with stable address/data until ack.
- i_pnt_we  in  1  1 = write, 0 = read.
- i_pnt_addr  in  ADDR_W  painter pixel address.
- i_pnt_wdata_1, i_pnt_wdata_2  in  16 each  write words for even/odd address.
- o_pnt_ack  out  1  one-cycle pulse: request accepted.
- o_pnt_valid  out  1  one-cycle pulse: read data valid (reads only).
- o_pnt_rdata_1, o_pnt_rdata_2  out  16 each  painter read words.
- o_SRAM_ADDR  out  ADDR_W+1  word address.
- io_SRAM_DQ  inout  16  data bus; driven only during write cycles, else high-Z.
- o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  active-low SRAM controls.

## Operation
- FSM states: IDLE, ACC0 (even word), ACC1 (odd word).
- Arbitration happens in IDLE and in ACC1:
  - Painter wins if i_pnt_req && (!i_disp_req || starve_cnt == STARVE_LIMIT).
  - Otherwise display wins if i_disp_req.
  - With no request, go to or stay in IDLE.
- On a grant:
  - Latch owner, we, addr and both wdata words.
  - Next state ACC0.
  - The owner's ack is high for exactly the ACC0 cycle.
- ACC0:
  - o_SRAM_ADDR = {addr,1'b0}.
  - Read: OE_N=0 and DQ is sampled into word-1 register at the end of the cycle.
  - Write: WE_N=0 and DQ = wdata_1.
  - Next state ACC1.
- ACC1: same as ACC0 with {addr,1'b1} and word 2. Arbitrates for a back-to-back ACC0; otherwise returns to IDLE.
- Read completion:
  - The owner's valid pulses the cycle after ACC1.
  - The owner's data registers update in that same cycle and hold until the next read completion for that owner.
- Writes produce no valid pulse.
- CE_N, LB_N and UB_N are 0 in ACC0/ACC1 and 1 in IDLE. WE_N and OE_N are never low together.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each display grant while i_pnt_req=1.
  - Clears on a painter grant or whenever i_pnt_req=0.

## Timing
- Reset values:
  - All acks and valids 0; data outputs 0.
  - o_SRAM_ADDR 0; all SRAM *_N outputs 1; DQ high-Z.
  - FSM IDLE; starve_cnt 0.
- All outputs are registered; no combinational path from the requests to any output.
- Latency:
  - Request high at edge k in IDLE: ack in cycle k+1 (ACC0), ACC1 in k+2, valid/data in k+3.
- Throughput: one pixel per 2 cycles under continuous requests (ACC1→ACC0 with no IDLE).
- A requester must keep req and its inputs stable until it samples ack=1. A request still high the cycle after ack is treated as a new request.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: display first; the painter is granted at the next arbitration point if the display drops its request.
- Reset asserted mid-burst:
  - The FSM and all outputs return to reset values immediately (asynchronously).
  - The aborted transaction produces no valid pulse.
  - A partially written pixel is not rolled back.
- The painter cannot be starved beyond STARVE_LIMIT display grants. The worst-case display wait is one painter burst (2 cycles).

## Test plan
- Display read of addr 0x00010, SRAM model holding 0x1234 at 0x20 and 0xABCD at 0x21 → ack in cycle k+1; valid in k+3 with data_1=0x1234, data_2=0xABCD; o_SRAM_ADDR = 0x20 then 0x21.
- Painter write addr 0x7FFFF, wdata 0xFFFF/0x0001, then painter read of the same address → WE_N low for 2 cycles at 0xFFFFE/0xFFFFF; the read returns 0xFFFF/0x0001; no valid on the write.
- Both requests asserted in the same cycle (starve_cnt=0) → display acked first; the painter is acked at the next ACC1 after the display deasserts.
- Display request held high continuously plus a painter request → exactly 8 display grants, then a painter grant, then display resumes; starve_cnt is back to 0.
- 16 back-to-back display reads → 16 valid pulses spaced exactly 2 cycles apart; no IDLE cycles in between.
- i_rst_n pulled low during ACC1 of a read → the valid pulse is suppressed, all SRAM *_N outputs go to 1, and DQ goes high-Z at once; after release, a new request is serviced with normal latency.
